// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO for the EX stage.
// Define MDU_MADD_EN to enable MADD/MSUB accumulate ops (7/8).
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ReadHILO,
    output logic [WIDTH-1:0] RData,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         op_q;

    logic               is_mul;
    logic               is_div;

    logic [2*WIDTH-1:0] sa;
    logic [2*WIDTH-1:0] sb;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   ua;
    logic [WIDTH-1:0]   ub;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    logic               wb_en;
    logic [2*WIDTH-1:0] wb;

`ifdef MDU_MADD_EN
    assign is_mul = (MDUOP == OP_MULT) | (MDUOP == OP_MULTU) |
                    (MDUOP == OP_MADD) | (MDUOP == OP_MSUB);
`else
    assign is_mul = (MDUOP == OP_MULT) | (MDUOP == OP_MULTU);
`endif
    assign is_div = (MDUOP == OP_DIV) | (MDUOP == OP_DIVU);

    assign Busy  = (cnt != '0);
    assign Stall = Busy | (Start & (is_mul | is_div));

    always_comb begin
        RData = '0;
        case (ReadHILO)
            2'd1:    RData = HI;
            2'd2:    RData = LO;
            default: RData = '0;
        endcase
    end

    // Low 2*WIDTH bits of a sign-extended product equal the signed product
    assign sa    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign sb    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign sprod = sa * sb;
    assign uprod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide via magnitudes; MIN/-1 falls out as MIN with rem 0
    assign a_neg = (op_q == OP_DIV) & a_q[WIDTH-1];
    assign b_neg = (op_q == OP_DIV) & b_q[WIDTH-1];
    assign ua    = a_neg ? -a_q : a_q;
    assign ub    = b_neg ? -b_q : b_q;
    assign uq    = (ub == '0) ? '0 : ua / ub;
    assign ur    = (ub == '0) ? '0 : ua % ub;
    assign quo   = (a_neg ^ b_neg) ? -uq : uq;
    assign rem   = a_neg ? -ur : ur;

    always_comb begin
        wb_en = 1'b0;
        wb    = '0;
        case (op_q)
            OP_MULT: begin
                wb_en = 1'b1;
                wb    = sprod;
            end
            OP_MULTU: begin
                wb_en = 1'b1;
                wb    = uprod;
            end
            OP_DIV, OP_DIVU: begin
                wb_en = (b_q != '0);
                wb    = {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                wb_en = 1'b1;
                wb    = {HI, LO} + sprod;
            end
            OP_MSUB: begin
                wb_en = 1'b1;
                wb    = {HI, LO} - sprod;
            end
`endif
            default: begin
                wb_en = 1'b0;
                wb    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            HI   <= '0;
            LO   <= '0;
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && wb_en) begin
                HI <= wb[2*WIDTH-1:WIDTH];
                LO <= wb[WIDTH-1:0];
            end
        end else if (Start) begin
            if (is_mul | is_div) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= MDUOP;
                cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (MDUOP == OP_MTHI) begin
                HI <= A;
            end else if (MDUOP == OP_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table plus hand sequences
// for mid-run Start and mid-run reset.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOP;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ReadHILO;
    logic [31:0] RData;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .MDUOP(MDUOP),
        .A(A),
        .B(B),
        .ReadHILO(ReadHILO),
        .RData(RData),
        .Busy(Busy),
        .Stall(Stall),
        .HI(HI),
        .LO(LO)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vq[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input int cyc);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.hi = hi; v.lo = lo; v.cyc = cyc;
        vq.push_back(v);
    endtask

    // Pulse Start for one edge, then count Busy cycles (bounded)
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc,
                         output logic stall);
        @(negedge clk);
        Start = 1'b1; MDUOP = op; A = a; B = b;
        #1 stall = Stall;
        @(negedge clk);
        Start = 1'b0; MDUOP = 4'd0;
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   c;
        int   n;
        logic s;

        add("mult_neg", 4'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC);
        add("multu", 4'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, MC);
        add("mult_min", 4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, MC);
        add("div_neg", 4'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        add("div_negb", 4'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, DC);
        add("divu", 4'd4, 32'h7, 32'h2, 32'h1, 32'h3, DC);
        add("mthi", 4'd5, 32'h12345678, 32'h0, 32'h12345678, 32'h3, 0);
        add("divu_by0", 4'd4, 32'h5, 32'h0, 32'h12345678, 32'h3, DC);
        add("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DC);
        add("mtlo", 4'd6, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
        add("op_none", 4'd0, 32'h55, 32'h66, 32'h0, 32'hFFFFFFFF, 0);
        add("op_12", 4'd12, 32'h55, 32'h66, 32'h0, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
        add("madd", 4'd7, 32'h1, 32'h1, 32'h1, 32'h0, MC);
        add("msub", 4'd8, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, MC);
`else
        add("madd_off", 4'd7, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0);
        add("msub_off", 4'd8, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0);
`endif

        reset = 1'b0; Start = 1'b0; MDUOP = 4'd0;
        A = '0; B = '0; ReadHILO = 2'd1;
        repeat (3) @(negedge clk);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_rdata", RData, 32'h0);
        reset = 1'b1;
        ReadHILO = 2'd0;

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].a, vq[i].b, c, s);
            chk({vq[i].name, "_cyc"}, c, vq[i].cyc);
            chk({vq[i].name, "_stall"}, {31'b0, s},
                {31'b0, (vq[i].cyc != 0)});
            chk({vq[i].name, "_hi"}, HI, vq[i].hi);
            chk({vq[i].name, "_lo"}, LO, vq[i].lo);
            ReadHILO = 2'd1; #1;
            chk({vq[i].name, "_rd_hi"}, RData, vq[i].hi);
            ReadHILO = 2'd2; #1;
            chk({vq[i].name, "_rd_lo"}, RData, vq[i].lo);
            ReadHILO = 2'd3; #1;
            chk({vq[i].name, "_rd_3"}, RData, 32'h0);
            ReadHILO = 2'd0;
        end

        // Start during RUN must be ignored, old LO readable meanwhile
        issue(4'd6, 32'h1111, 32'h0, c, s);
        @(negedge clk);
        Start = 1'b1; MDUOP = 4'd1; A = 32'h3; B = 32'h5;
        @(negedge clk);
        Start = 1'b0; MDUOP = 4'd0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            if (n == 2) begin
                Start = 1'b1; MDUOP = 4'd6; A = 32'hDEAD; ReadHILO = 2'd2;
                #1;
                chk("run_stall", {31'b0, Stall}, 32'h1);
                chk("run_old_lo", RData, 32'h1111);
            end else begin
                Start = 1'b0; MDUOP = 4'd0; ReadHILO = 2'd0;
            end
            @(negedge clk);
        end
        Start = 1'b0; MDUOP = 4'd0; ReadHILO = 2'd0;
        chk("run_cyc", n, MC);
        chk("run_lo", LO, 32'hF);
        chk("run_hi", HI, 32'h0);

        // Reset in the middle of a divide discards the result
        issue(4'd5, 32'hAAAA, 32'h0, c, s);
        @(negedge clk);
        Start = 1'b1; MDUOP = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDUOP = 4'd0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, Busy}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_hi", HI, 32'h0);
        chk("mid_rst_lo", LO, 32'h0);
        chk("mid_rst_busy", {31'b0, Busy}, 32'h0);
        repeat (12) @(negedge clk);
        chk("late_hi", HI, 32'h0);
        chk("late_lo", LO, 32'h0);
        chk("late_busy", {31'b0, Busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
